// File: rtl/axis_video_frame_arbiter.sv
// rtl/axis_video_frame_arbiter.sv - frame-granular round-robin arbiter for two AXI4-Stream video sources
module axis_video_frame_arbiter #(
  parameter int N       = 8,
  parameter int WIDTH   = 10,
  parameter int HEIGHT  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         en,
  input  logic [N-1:0] s0_tdata,
  input  logic         s0_tvalid,
  output logic         s0_tready,
  input  logic         s0_tlast,
  input  logic         s0_tuser,
  input  logic [N-1:0] s1_tdata,
  input  logic         s1_tvalid,
  output logic         s1_tready,
  input  logic         s1_tlast,
  input  logic         s1_tuser,
  output logic [N-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic         m_tuser,
  output logic         active_src,
  output logic         busy,
  output logic         frame_done,
  output logic         sof_err,
  output logic         timeout_err,
  output logic         line_err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;
  localparam int PW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(HEIGHT + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [0:0]    state_q, state_d;
  logic          active_q, active_d;
  logic          last_grant_q, last_grant_d;
  logic          started_q, started_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          frame_done_d, sof_err_d, timeout_err_d, line_err_d;

  logic [N-1:0]  sel_tdata;
  logic          sel_tvalid, sel_tlast, sel_tuser, sel_tready;
  logic          streaming, early_sof, fwd_ready, accept;
  logic          req0, req1, frame_end, timeout_hit;

  always_comb begin
    sel_tdata  = active_q ? s1_tdata  : s0_tdata;
    sel_tvalid = active_q ? s1_tvalid : s0_tvalid;
    sel_tlast  = active_q ? s1_tlast  : s0_tlast;
    sel_tuser  = active_q ? s1_tuser  : s0_tuser;
    sel_tready = ~m_tvalid | m_tready;
    streaming  = (state_q == S_STREAM);
    // A second SOF inside a started frame is held back so it can re-compete.
    early_sof  = streaming & sel_tvalid & sel_tuser & started_q;
    fwd_ready  = streaming & sel_tready & ~early_sof;
    accept     = fwd_ready & sel_tvalid;
    // Idle: non-SOF beats are flushed, SOF beats wait for a grant.
    s0_tready  = streaming ? (~active_q & fwd_ready) : ~s0_tuser;
    s1_tready  = streaming ? ( active_q & fwd_ready) : ~s1_tuser;
    req0       = s0_tvalid & s0_tuser;
    req1       = s1_tvalid & s1_tuser;
    frame_end  = accept & sel_tlast & (line_cnt_q == LW'(HEIGHT - 1));
    timeout_hit = streaming & ~sel_tvalid & (idle_cnt_q == IW'(TIMEOUT - 1));
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    last_grant_d  = last_grant_q;
    started_d     = started_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    frame_done_d  = 1'b0;
    sof_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    line_err_d    = accept & sel_tlast & (pix_cnt_q != PW'(WIDTH - 1));
    if (!streaming) begin
      if (en && (req0 || req1)) begin
        state_d    = S_STREAM;
        active_d   = (req0 && req1) ? ~last_grant_q : req1;
        started_d  = 1'b0;
        pix_cnt_d  = '0;
        line_cnt_d = '0;
        idle_cnt_d = '0;
      end
    end else begin
      if (accept) begin
        started_d = 1'b1;
        if (sel_tlast) begin
          pix_cnt_d  = '0;
          line_cnt_d = line_cnt_q + LW'(1);
        end else begin
          pix_cnt_d = pix_cnt_q + PW'(1);
        end
      end
      idle_cnt_d = sel_tvalid ? '0 : idle_cnt_q + IW'(1);
      if (frame_end || early_sof || timeout_hit) begin
        frame_done_d  = frame_end;
        sof_err_d     = ~frame_end & early_sof;
        timeout_err_d = ~frame_end & ~early_sof & timeout_hit;
        state_d       = S_IDLE;
        last_grant_d  = active_q;
        started_d     = 1'b0;
        pix_cnt_d     = '0;
        line_cnt_d    = '0;
        idle_cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      active_q     <= 1'b0;
      last_grant_q <= 1'b1;
      started_q    <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      frame_done   <= 1'b0;
      sof_err      <= 1'b0;
      timeout_err  <= 1'b0;
      line_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      last_grant_q <= last_grant_d;
      started_q    <= started_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      frame_done   <= frame_done_d;
      sof_err      <= sof_err_d;
      timeout_err  <= timeout_err_d;
      line_err     <= line_err_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else if (accept) begin
      m_tdata  <= sel_tdata;
      m_tvalid <= 1'b1;
      m_tlast  <= sel_tlast;
      m_tuser  <= sel_tuser;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  assign active_src = active_q;
  assign busy       = streaming;

endmodule

// File: tb/tb_axis_video_frame_arbiter.sv
// tb/tb_axis_video_frame_arbiter.sv - randomized scenario bench with frame-level scoreboard
module tb_axis_video_frame_arbiter;

  typedef logic [9:0] beat_q_t[$];

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       en = 1'b1;
  logic [7:0] s0_tdata = '0, s1_tdata = '0;
  logic       s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tuser = 1'b0, s0_tready;
  logic       s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tuser = 1'b0, s1_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tuser;
  logic       m_tready = 1'b1;
  logic       active_src, busy, frame_done, sof_err, timeout_err, line_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit bp_mode = 1'b0;

  beat_q_t got;
  int got_cyc[$];
  int in0_cyc[$];
  int in1_cnt, fd_cnt, se_cnt, to_cnt, le_cnt;
  logic grants[$];
  logic busy_prev;

  axis_video_frame_arbiter #(.N(8), .WIDTH(10), .HEIGHT(10), .TIMEOUT(64)) dut (
    .clk(clk), .aresetn(aresetn), .en(en),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .active_src(active_src), .busy(busy), .frame_done(frame_done),
    .sof_err(sof_err), .timeout_err(timeout_err), .line_err(line_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: everything is sampled on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_tvalid && m_tready) begin
      got.push_back({m_tuser, m_tlast, m_tdata});
      got_cyc.push_back(cyc);
    end
    if (s0_tvalid && s0_tready) in0_cyc.push_back(cyc);
    if (s1_tvalid && s1_tready) in1_cnt++;
    fd_cnt += int'(frame_done);
    se_cnt += int'(sof_err);
    to_cnt += int'(timeout_err);
    le_cnt += int'(line_err);
    if (busy && !busy_prev) grants.push_back(active_src);
    busy_prev = busy;
  end

  // A frame as the source emits it: tuser on beat 0, tlast closing each line.
  function automatic beat_q_t make_frame(int h, int short_line);
    beat_q_t q;
    for (int l = 0; l < h; l++) begin
      int w = (l == short_line) ? 9 : 10;
      for (int p = 0; p < w; p++)
        q.push_back({(l == 0 && p == 0), (p == w - 1), 8'($urandom_range(0, 255))});
    end
    return q;
  endfunction

  function automatic int first_diff(beat_q_t a, beat_q_t b);
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] !== b[i]) return i;
    return (a.size() == b.size()) ? -1 : ((a.size() < b.size()) ? a.size() : b.size());
  endfunction

  task automatic clear_mon();
    got.delete(); got_cyc.delete(); in0_cyc.delete(); grants.delete();
    in1_cnt = 0; fd_cnt = 0; se_cnt = 0; to_cnt = 0; le_cnt = 0;
    busy_prev = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    clear_mon();
  endtask

  task automatic drive_beat(input int src, input logic [9:0] b);
    bit fire = 1'b0;
    if (src == 0) begin
      {s0_tuser, s0_tlast, s0_tdata} = b; s0_tvalid = 1'b1;
    end else begin
      {s1_tuser, s1_tlast, s1_tdata} = b; s1_tvalid = 1'b1;
    end
    for (int c = 0; c < 3000 && !fire; c++) begin
      @(negedge clk);
      fire = (src == 0) ? s0_tready : s1_tready;
      @(posedge clk);
      #1;
    end
    if (src == 0) s0_tvalid = 1'b0; else s1_tvalid = 1'b0;
    if (!fire) begin
      n_chk++; n_fail++;
      $display("FAIL handshake_wait src%0d: tready never seen, required 1", src);
    end
  endtask

  task automatic send_frame(input int src, input beat_q_t q, input int gapmax);
    foreach (q[i]) begin
      drive_beat(src, q[i]);
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    beat_q_t p;
    @(negedge clk);
    n_chk++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser, busy, active_src, frame_done, sof_err,
         timeout_err, line_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b busy=%b data=%h, required all 0", m_tvalid, busy, m_tdata);
    end
    do_reset();
    p = make_frame(10, -1);
    p = p[0:19];
    send_frame(0, p, 0);
    aresetn = 1'b0;
    #1;
    n_chk++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe: got m_tvalid=%b busy=%b, required 0 0", m_tvalid, busy);
    end
    settle(1);
    aresetn = 1'b1;
    clear_mon();
    drive_beat(0, {2'b00, 8'h5a});
    settle(3);
    n_chk++;
    if (got.size() != 0 || busy !== 1'b0 || in0_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL reset_needs_sof: got out=%0d busy=%b flushed=%0d, required 0 0 1", got.size(), busy, in0_cyc.size());
    end
  endtask

  task automatic test_single_frame();
    beat_q_t f;
    int d, tl, tu, lat_bad;
    do_reset();
    f = make_frame(10, -1);
    send_frame(0, f, 0);
    settle(3);
    d = first_diff(got, f);
    n_chk++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL single_data: diverges at beat %0d (got %0d beats, required %0d)", d, got.size(), f.size());
    end
    tl = 0; tu = 0;
    foreach (got[i]) begin tl += int'(got[i][8]); tu += int'(got[i][9]); end
    n_chk++;
    if (tl != 10 || tu != 1 || (got.size() > 0 && got[0][9] !== 1'b1)) begin
      n_fail++;
      $display("FAIL single_markers: got tlast=%0d tuser=%0d, required 10 1 on beat 0", tl, tu);
    end
    n_chk++;
    if (fd_cnt != 1 || le_cnt != 0) begin
      n_fail++;
      $display("FAIL single_status: got frame_done=%0d line_err=%0d, required 1 0", fd_cnt, le_cnt);
    end
    lat_bad = 0;
    foreach (got_cyc[i]) if (i >= in0_cyc.size() || got_cyc[i] != in0_cyc[i] + 1) lat_bad++;
    n_chk++;
    if (lat_bad != 0 || got_cyc.size() != 100) begin
      n_fail++;
      $display("FAIL single_latency: got %0d beats not 1 clk after input of %0d, required 0 of 100", lat_bad, got_cyc.size());
    end
    n_chk++;
    if (got_cyc.size() == 100 && got_cyc[99] - got_cyc[0] != 99) begin
      n_fail++;
      $display("FAIL single_no_bubble: got span %0d, required 99", got_cyc[99] - got_cyc[0]);
    end
  endtask

  task automatic test_round_robin();
    beat_q_t a, b, c, exp;
    int d;
    do_reset();
    a = make_frame(10, -1); b = make_frame(10, -1); c = make_frame(10, -1);
    fork
      begin send_frame(0, a, 1); send_frame(0, c, 1); end
      send_frame(1, b, 1);
    join
    settle(3);
    exp = {a, b, c};
    d = first_diff(got, exp);
    n_chk++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL rr_order: diverges at beat %0d (got %0d beats, required %0d)", d, got.size(), exp.size());
    end
    n_chk++;
    if (grants.size() != 3 || grants[0] !== 1'b0 || grants[1] !== 1'b1 || grants[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_grants: got %0d grants, required sequence 0,1,0", grants.size());
    end
    n_chk++;
    if (fd_cnt != 3) begin
      n_fail++;
      $display("FAIL rr_frame_done: got %0d, required 3", fd_cnt);
    end
  endtask

  task automatic test_flush();
    beat_q_t f;
    int d;
    do_reset();
    for (int i = 0; i < 3; i++) drive_beat(1, {1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))});
    settle(2);
    n_chk++;
    if (in1_cnt != 3 || got.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: got accepted=%0d out=%0d busy=%b, required 3 0 0", in1_cnt, got.size(), busy);
    end
    f = make_frame(10, -1);
    en = 1'b0;
    fork
      send_frame(1, f, 0);
      begin
        repeat (10) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_en_low: got busy=%b, required 0", busy);
        end
        @(posedge clk); #1;
        en = 1'b1;
      end
    join
    settle(3);
    d = first_diff(got, f);
    n_chk++;
    if (d != -1 || grants.size() != 1 || grants[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_then_grant: diverges at %0d, grants=%0d, required -1 and one grant to src1", d, grants.size());
    end
  endtask

  task automatic test_timeout();
    beat_q_t p, f, exp;
    int d, n;
    do_reset();
    p = make_frame(10, -1);
    p = p[0:29];
    f = make_frame(10, -1);
    fork
      begin
        send_frame(0, p, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!timeout_err && n < 200);
        n_chk++;
        if (n != 65 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_cycle: got pulse at negedge %0d busy=%b, required 65 0", n, busy);
        end
      end
      begin
        for (int w = 0; w < 100 && !busy; w++) begin @(posedge clk); #1; end
        send_frame(1, f, 0);
      end
    join
    settle(3);
    exp = {p, f};
    d = first_diff(got, exp);
    n_chk++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL timeout_data: diverges at beat %0d (got %0d, required %0d)", d, got.size(), exp.size());
    end
    n_chk++;
    if (to_cnt != 1 || fd_cnt != 1 || le_cnt != 0 || grants.size() != 2 || grants[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_status: got to=%0d fd=%0d le=%0d grants=%0d, required 1 1 0 2 ending src1", to_cnt, fd_cnt, le_cnt, grants.size());
    end
  endtask

  task automatic test_early_sof();
    beat_q_t p, f, exp;
    int d;
    do_reset();
    p = make_frame(10, -1);
    p = p[0:24];
    f = make_frame(10, -1);
    send_frame(0, p, 1);
    send_frame(0, f, 1);
    settle(3);
    exp = {p, f};
    d = first_diff(got, exp);
    n_chk++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL sof_data: diverges at beat %0d (got %0d, required %0d)", d, got.size(), exp.size());
    end
    n_chk++;
    if (se_cnt != 1 || fd_cnt != 1 || to_cnt != 0) begin
      n_fail++;
      $display("FAIL sof_status: got sof=%0d fd=%0d to=%0d, required 1 1 0", se_cnt, fd_cnt, to_cnt);
    end
    n_chk++;
    if (in0_cyc.size() != 125 || grants.size() != 2) begin
      n_fail++;
      $display("FAIL sof_not_consumed: got %0d handshakes %0d grants, required 125 2", in0_cyc.size(), grants.size());
    end
  endtask

  task automatic test_backpressure();
    beat_q_t f;
    int d;
    do_reset();
    bp_mode = 1'b1;
    f = make_frame(10, 4);
    send_frame(0, f, 2);
    settle(6);
    bp_mode = 1'b0;
    settle(2);
    d = first_diff(got, f);
    n_chk++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL bp_data: diverges at beat %0d (got %0d, required %0d)", d, got.size(), f.size());
    end
    n_chk++;
    if (fd_cnt != 1 || le_cnt != 1 || to_cnt != 0) begin
      n_fail++;
      $display("FAIL bp_status: got fd=%0d le=%0d to=%0d, required 1 1 0", fd_cnt, le_cnt, to_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_flush();
    test_timeout();
    test_early_sof();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
